seg_scan_scheduler: RTL and testbench

//  Time-multiplexed scan scheduler for the 8-digit common-anode 7-segment display.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/hex_to_7seg.sv | 11 +
 rtl/seg_scan_scheduler.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared encodings and lookup data for the 7-segment scan path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  // Level that switches one anode strobe off; replicate per digit for the full bus.
  localparam logic       AN_OFF  = 1'b1;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Multiplexed scan of an N-digit common-anode display with inter-digit blanking
// and a shadow/active double buffer that swaps only on frame boundaries.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic                    frame_done
);

  localparam int unsigned IdxW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TimerMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] ShowLast  = TimerW'(REFRESH_DIV - 1);
  localparam logic [TimerW-1:0] BlankLast = TimerW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam state_e AfterAdvance = (BLANK_CYCLES == 0) ? StShow : StBlank;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [4*NUM_DIGITS-1:0] shadow_digits_q, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_en_q, act_en_q, act_en_d;
  logic [IdxW-1:0]         nxt_idx;
  logic                    frame_done_d;
  logic [3:0]              nibble_d;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  // Circular search upward from cur+1; returns cur itself when it is the only set bit.
  function automatic logic [IdxW-1:0] next_enabled(input logic [NUM_DIGITS-1:0] en,
                                                   input logic [IdxW-1:0]       cur);
    logic [IdxW-1:0] r;
    logic [IdxW-1:0] j;
    logic            found;
    r     = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
      j = IdxW'((32'(cur) + k) % NUM_DIGITS);
      if (!found && en[j]) begin
        r     = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [IdxW-1:0] lowest_set(input logic [NUM_DIGITS-1:0] en);
    logic [IdxW-1:0] r;
    logic [IdxW-1:0] j;
    r = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      j = IdxW'(i);
      if (en[j]) r = j;
    end
    return r;
  endfunction

  assign nxt_idx = next_enabled(act_en_q, idx_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q + TimerW'(1);
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (shadow_en_q != '0) begin
          act_digits_d = shadow_digits_q;
          act_dp_d     = shadow_dp_q;
          act_en_d     = shadow_en_q;
          idx_d        = lowest_set(shadow_en_q);
          state_d      = AfterAdvance;
        end
      end
      StBlank: begin
        if (timer_q == BlankLast) begin
          timer_d = '0;
          state_d = StShow;
        end
      end
      StShow: begin
        if (timer_q == ShowLast) begin
          timer_d = '0;
          state_d = AfterAdvance;
          if (nxt_idx <= idx_q) begin
            // Wrap: swap in the pre-edge shadow and restart from its lowest enabled digit.
            frame_done_d = 1'b1;
            act_digits_d = shadow_digits_q;
            act_dp_d     = shadow_dp_q;
            act_en_d     = shadow_en_q;
            idx_d        = lowest_set(shadow_en_q);
            if (shadow_en_q == '0) state_d = StIdle;
          end else begin
            idx_d = nxt_idx;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign nibble_d = act_digits_d[{idx_d, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble_d),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d  = {NUM_DIGITS{AN_OFF}};
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == StShow) begin
      an_d[idx_d] = ~AN_OFF;
      seg_d       = dec_seg;
      dp_d        = ~act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      timer_q         <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      shadow_en_q     <= '0;
      act_digits_q    <= '0;
      act_dp_q        <= '0;
      act_en_q        <= '0;
      AN              <= {NUM_DIGITS{AN_OFF}};
      SEG             <= SEG_OFF;
      DP              <= 1'b1;
      frame_done      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      AN           <= an_d;
      SEG          <= seg_d;
      DP           <= dp_d;
      frame_done   <= frame_done_d;
      if (load) begin
        shadow_digits_q <= digits_in;
        shadow_dp_q     <= dp_in;
        shadow_en_q     <= digit_en;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: per-cycle frame-schedule model plus directed literal checks.
module tb_seg_scan_scheduler;

  localparam int unsigned N   = 8;
  localparam int unsigned RD  = 4;
  localparam int unsigned BC  = 2;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  localparam obs_t ObsOff = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_done;

  int vectors = 0;
  int errors  = 0;

  seg_scan_scheduler #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .AN         (AN),
    .SEG        (SEG),
    .DP         (DP),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Model: a frame is the list of enabled digits, each preceded by a gap, expanded to cycles.
  obs_t        sched[$];
  obs_t        exp_o = ObsOff;
  logic        running = 1'b0;
  logic [31:0] sh_dig = '0;
  logic [7:0]  sh_dp = '0;
  logic [7:0]  sh_en = '0;

  task automatic build_frame(input logic [31:0] dig, input logic [7:0] dpv, input logic [7:0] en);
    obs_t o;
    for (int d = 0; d < 8; d++) begin
      if (en[d]) begin
        for (int b = 0; b < int'(BC); b++) sched.push_back(ObsOff);
        o.an  = ~(8'h01 << d);
        o.seg = hex_seg(dig[4*d +: 4]);
        o.dp  = ~dpv[d];
        o.fd  = 1'b0;
        for (int s = 0; s < int'(RD); s++) sched.push_back(o);
      end
    end
  endtask

  initial begin
    logic boundary;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        sched.delete();
        running = 1'b0;
        sh_dig  = '0;
        sh_dp   = '0;
        sh_en   = '0;
        exp_o   = ObsOff;
      end else begin
        if (sched.size() == 0) begin
          boundary = running;
          if (sh_en != 8'h00) begin
            build_frame(sh_dig, sh_dp, sh_en);
            running = 1'b1;
            exp_o   = sched.pop_front();
          end else begin
            running = 1'b0;
            exp_o   = ObsOff;
          end
          exp_o.fd = boundary;
        end else begin
          exp_o = sched.pop_front();
        end
        if (load) begin
          sh_dig = digits_in;
          sh_dp  = dp_in;
          sh_en  = digit_en;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if ({AN, SEG, DP, frame_done} !== exp_o) begin
        errors++;
        $display("FAIL cycle t=%0t: got AN=%h SEG=%h DP=%b fd=%b, want AN=%h SEG=%h DP=%b fd=%b",
                 $time, AN, SEG, DP, frame_done, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fd);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic wait_an(input logic [7:0] v, input string nm);
    int n = 0;
    while (AN !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(AN), 32'(v));
  endtask

  task automatic wait_fd(input string nm);
    int n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(frame_done), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] dig, input logic [7:0] dpv, input logic [7:0] en);
    digits_in = dig;
    dp_in     = dpv;
    digit_en  = en;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  initial begin
    int n_fd, n_fe, n_7f, n_other, n_dp;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset AN", 32'(AN), 32'hFF);
    chk("reset SEG", 32'(SEG), 32'h7F);
    chk("reset DP", 32'(DP), 32'h1);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle after release AN", 32'(AN), 32'hFF);

    // All eight digits 0..7
    do_load(32'h7654_3210, 8'h00, 8'hFF);
    wait_an(8'hFE, "reach digit0");
    chk("digit0 SEG", 32'(SEG), 32'h40);
    chk("digit0 DP", 32'(DP), 32'h1);
    wait_an(8'h7F, "reach digit7");
    chk("digit7 SEG", 32'(SEG), 32'h78);
    wait_fd("first frame_done");
    chk("AN off at frame_done", 32'(AN), 32'hFF);

    // Only digits 0 and 7, DP lit on digit 7
    wait_an(8'hFE, "mid-frame before en81 load");
    do_load(32'h7654_3210, 8'h80, 8'h81);
    wait_fd("boundary into en81");
    n_fd = 0; n_fe = 0; n_7f = 0; n_other = 0; n_dp = 0;
    for (int i = 0; i < 24; i++) begin
      if (frame_done === 1'b1) n_fd++;
      if (AN === 8'hFE) n_fe++;
      else if (AN === 8'h7F) begin
        n_7f++;
        if (DP === 1'b0) n_dp++;
      end else if (AN !== 8'hFF) n_other++;
      @(negedge clk);
    end
    chk("en81 frame_done count", 32'(n_fd), 32'd2);
    chk("en81 digit0 cycles", 32'(n_fe), 32'd8);
    chk("en81 digit7 cycles", 32'(n_7f), 32'd8);
    chk("en81 DP lit cycles", 32'(n_dp), 32'd8);
    chk("en81 stray anodes", 32'(n_other), 32'd0);

    // Mid-frame load must wait for the boundary
    wait_an(8'hFE, "digit0 before all-F load");
    do_load(32'hFFFF_FFFF, 8'h00, 8'hFF);
    chk("SEG held before boundary", 32'(SEG), 32'h40);
    wait_fd("boundary into all-F");
    wait_an(8'hFE, "digit0 of all-F frame");
    chk("all-F SEG", 32'(SEG), 32'h0E);

    // Disable everything: finish the frame then go dark
    do_load(32'hFFFF_FFFF, 8'h00, 8'h00);
    wait_fd("last frame_done");
    n_fd = 0; n_other = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) n_fd++;
      if (AN !== 8'hFF) n_other++;
    end
    chk("dark frame_done count", 32'(n_fd), 32'd0);
    chk("dark anode count", 32'(n_other), 32'd0);

    // Asynchronous reset mid-digit
    do_load(32'h7654_3210, 8'h00, 8'hFF);
    wait_an(8'hFB, "reach digit2");
    #2 reset = 1'b1;
    #1;
    chk("async reset AN", 32'(AN), 32'hFF);
    chk("async reset SEG", 32'(SEG), 32'h7F);
    chk("async reset DP", 32'(DP), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_other = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (AN !== 8'hFF) n_other++;
    end
    chk("idle after reset", 32'(n_other), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
